lector_contadores: RTL and testbench
====================================

Name: lector_contadores

Overview:
- Requester/collector at the far end of the counter-readout interface. Drives idx plus a request strobe and collects the valid/data_out replies from the pop-counter block.
- On a start pulse it sweeps indices 0..NUM_CNT-1, captures each returned count into an output register, then pulses done.
- A per-request timeout guards against a responder that never asserts valid.
- Sits between the counter block and test/control logic, so the probador or upper FSM sees a full coherent snapshot instead of driving idx by hand.

Parameters:
- NUM_CNT, 5, number of counters swept (indices 0..NUM_CNT-1); max 8.
- WIDTH, 5, width of each count word.
- IDX_W, 3, width of idx.
- TIMEOUT, 8, cycles waited in WAIT for valid before aborting; must be >=2.

Ports:
- clk  input  1  single clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; ignored while busy.
- valid  input  1  responder reply strobe.
- data_in  input  WIDTH  count value; qualified by valid.
- req  output  1  one-cycle request strobe to the responder.
- idx  output  IDX_W  counter index being requested; held stable from REQ through WAIT.
- cnt_0..cnt_4  output  WIDTH each  captured counts, one register per index.
- busy  output  1  high in REQ/WAIT.
- done  output  1  one-cycle pulse when a sweep ends (normal or aborted).
- err  output  1  sticky timeout flag; cleared on next accepted start.

Behaviour:
- Reset (reset_L=0, asynchronous): state=IDLE, req=0, idx=0, busy=0, done=0, err=0, cnt_0..cnt_4=0, timer=0. Reset mid-sweep abandons the sweep with no done pulse.
- Outputs are registered and change only on rising clk, except for the asynchronous reset.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: req=0, busy=0.
  - start=1 -> REQ, with idx=0, err=0, timer=0.
  - cnt_* hold their previous values until overwritten.
- REQ: req=1 for exactly this cycle, busy=1 -> WAIT. valid during REQ is ignored.
- WAIT: req=0, busy=1, idx held, timer increments each cycle.
  - valid=1: cnt_[idx] <= data_in, timer=0.
    - If idx==NUM_CNT-1 -> DONE.
    - Otherwise idx <= idx+1 -> REQ.
  - valid=0 and timer==TIMEOUT-1: err <= 1, cnt_[idx] unchanged -> DONE (abort; remaining indices are not requested).
- DONE: done=1 for one cycle, busy=0, idx returns to 0 -> IDLE. start during DONE is ignored.
- Timing with a responder answering one cycle after req:
  - start sampled at edge 0: REQ in cycle 1 (idx=0), WAIT in cycle 2.
  - Each index costs 2 cycles; done is high in cycle 2*NUM_CNT+1 (cycle 11 for defaults).
- valid arriving in IDLE or DONE is ignored; no captures occur.
- A valid with the timer at TIMEOUT-1 counts as a reply, not a timeout. Capture has priority.
- start while busy: ignored; no restart and no queuing.
- Counts are stored verbatim with no arithmetic; WIDTH bits straight through.

Test Plan:
- Reset then idle: reset_L=0 for 2 cycles, then 1 -> all cnt_*=0, req=0, busy=0, done=0, err=0; valid pulses in IDLE leave cnt_* at 0.
- Normal sweep: responder returns 5'd3, 5'd7, 5'd0, 5'd31, 5'd12, one cycle after each req -> idx sequence 0,1,2,3,4; cnt_0..4 = 3,7,0,31,12; done high in cycle 11; err=0.
- Slow responder: valid 4 cycles after each req (TIMEOUT=8) -> all values captured; done in cycle 1+5*5 = 26; err=0.
- Timeout: responder silent on idx=2 -> err=1 after 8 WAIT cycles; done pulses; cnt_2 keeps its old value; idx 3 and 4 are never requested (no req with idx=3).
- start while busy: extra start pulses mid-sweep -> exactly 5 req pulses and one done. A new start after done restarts the sweep and clears err.
- Reset mid-sweep: reset_L=0 during WAIT with idx=3 -> immediately busy=0, req=0, idx=0, cnt_*=0; no done pulse; a following start runs a full clean sweep.

Source files
------------

// File: rtl/lector_contadores.sv
// lector_contadores: sweeps counter indices 0..NUM_CNT-1 over a req/valid
// readout link and captures each reply into its own output register.
//
// Ports:
//   clk       rising-edge clock
//   reset_L   asynchronous active-low reset
//   start     one-cycle sweep request (ignored unless idle)
//   valid     responder reply strobe, qualifies data_in
//   data_in   returned count word
//   req       one-cycle request strobe to the responder
//   idx       index being requested, stable from REQ through WAIT
//   cnt_0..4  captured count per index
//   busy      high while a sweep is in REQ/WAIT
//   done      one-cycle pulse when a sweep ends (normal or aborted)
//   err       sticky timeout flag, cleared by the next accepted start
module lector_contadores #(
    parameter int NUM_CNT = 5,
    parameter int WIDTH   = 5,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             req,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] cnt_0,
    output logic [WIDTH-1:0] cnt_1,
    output logic [WIDTH-1:0] cnt_2,
    output logic [WIDTH-1:0] cnt_3,
    output logic [WIDTH-1:0] cnt_4,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    // timer only needs to reach TIMEOUT-1
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CNT - 1);
    localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;
    logic             cap;
    logic [WIDTH-1:0] cnt_q [NUM_CNT];
    logic [WIDTH-1:0] cnt_o [5];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = '0;
        err_d   = err_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                // a reply on the last timer cycle still wins
                if (valid) begin
                    cap = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = REQ;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (timer_q == TMAX) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        req  = (state_q == REQ);
        busy = (state_q == REQ) || (state_q == WAIT);
        done = (state_q == DONE);
        idx  = idx_q;
        err  = err_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (cap && idx_q == IDX_W'(i)) begin
                    cnt_q[i] <= data_in;
                end
            end
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_out
        if (k < NUM_CNT) begin : g_used
            assign cnt_o[k] = cnt_q[k];
        end else begin : g_zero
            assign cnt_o[k] = '0;
        end
    end

    assign cnt_0 = cnt_o[0];
    assign cnt_1 = cnt_o[1];
    assign cnt_2 = cnt_o[2];
    assign cnt_3 = cnt_o[3];
    assign cnt_4 = cnt_o[4];

endmodule

// File: tb/tb_lector_contadores.sv
// tb_lector_contadores: table of sweep scenarios plus random sweeps,
// each checked against a sweep-level latency/capture model.
module tb_lector_contadores;

    localparam int NUM_CNT = 5;
    localparam int WIDTH   = 5;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             start;
    logic             valid;
    logic [WIDTH-1:0] data_in;
    logic             req;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] cnt_0, cnt_1, cnt_2, cnt_3, cnt_4;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    lector_contadores #(
        .NUM_CNT(NUM_CNT),
        .WIDTH  (WIDTH),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .start  (start),
        .valid  (valid),
        .data_in(data_in),
        .req    (req),
        .idx    (idx),
        .cnt_0  (cnt_0),
        .cnt_1  (cnt_1),
        .cnt_2  (cnt_2),
        .cnt_3  (cnt_3),
        .cnt_4  (cnt_4),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    logic [WIDTH-1:0] cnt_a [5];
    assign cnt_a[0] = cnt_0;
    assign cnt_a[1] = cnt_1;
    assign cnt_a[2] = cnt_2;
    assign cnt_a[3] = cnt_3;
    assign cnt_a[4] = cnt_4;

    int total  = 0;
    int passed = 0;

    logic [WIDTH-1:0] exp_cnt [5];

    // lat[i]: cycles from req to valid; 0 = never answers
    typedef struct {
        logic [4:0][3:0]       lat;
        logic [4:0][WIDTH-1:0] dat;
        bit                    extra;
        int                    rst_at;
        int                    exp_done;
        int                    exp_err;
        int                    exp_reqs;
    } row_t;

    row_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic row_t mk(
        input int l0, l1, l2, l3, l4,
        input int d0, d1, d2, d3, d4,
        input bit ex, input int ra,
        input int ed, input int ee, input int er
    );
        row_t t;
        t.lat[0] = 4'(l0);
        t.lat[1] = 4'(l1);
        t.lat[2] = 4'(l2);
        t.lat[3] = 4'(l3);
        t.lat[4] = 4'(l4);
        t.dat[0] = WIDTH'(d0);
        t.dat[1] = WIDTH'(d1);
        t.dat[2] = WIDTH'(d2);
        t.dat[3] = WIDTH'(d3);
        t.dat[4] = WIDTH'(d4);
        t.extra    = ex;
        t.rst_at   = ra;
        t.exp_done = ed;
        t.exp_err  = ee;
        t.exp_reqs = er;
        return t;
    endfunction

    // Sweep-level model: each answered index costs 1+lat cycles,
    // an unanswered one costs 1+TIMEOUT and ends the sweep.
    task automatic model(
        input  logic [4:0][3:0] lat,
        output int d, output int e, output int r
    );
        d = 1;
        e = 0;
        r = 0;
        for (int i = 0; i < NUM_CNT; i++) begin
            r++;
            if (lat[i] >= 1 && int'(lat[i]) <= TIMEOUT) begin
                d += 1 + int'(lat[i]);
            end else begin
                d += 1 + TIMEOUT;
                e = 1;
                break;
            end
        end
    endtask

    task automatic run_sweep(input row_t t, input string tg);
        int vcyc     = -1;
        int cur      = 0;
        int nreq     = 0;
        int ndone    = 0;
        int done_cyc = -1;
        int busy_n   = 0;
        int hold_bad = 0;
        int idx_bad  = 0;
        logic [IDX_W-1:0] last_idx = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(negedge clk);
            start = t.extra && cyc <= t.exp_done &&
                    (cyc % 3 == 0 || cyc == t.exp_done);
            if (busy) busy_n++;
            if (req) begin
                if (nreq >= NUM_CNT || idx != IDX_W'(nreq)) idx_bad++;
                last_idx = idx;
                if (nreq < NUM_CNT) begin
                    cur  = nreq;
                    vcyc = (t.lat[nreq] == 0) ? -1 : cyc + int'(t.lat[nreq]);
                end
                nreq++;
            end else if (busy && idx != last_idx) begin
                hold_bad++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (t.rst_at == cyc) begin
                chk({tg, "_pre_rst_idx"}, int'(idx), 3);
                chk({tg, "_pre_rst_busy"}, int'(busy), 1);
                reset_L = 1'b0;
                valid   = 1'b0;
                start   = 1'b0;
                #1;
                chk({tg, "_rst_busy"}, int'(busy), 0);
                chk({tg, "_rst_req"}, int'(req), 0);
                chk({tg, "_rst_idx"}, int'(idx), 0);
                chk({tg, "_rst_done"}, int'(done), 0);
                chk({tg, "_rst_err"}, int'(err), 0);
                chk({tg, "_rst_reqs"}, nreq, t.exp_reqs);
                chk({tg, "_rst_ndone"}, ndone, 0);
                for (int i = 0; i < 5; i++) begin
                    exp_cnt[i] = '0;
                    chk($sformatf("%s_rst_cnt%0d", tg, i),
                        int'(cnt_a[i]), 0);
                end
                @(negedge clk);
                reset_L = 1'b1;
                return;
            end
            valid   = (cyc == vcyc);
            data_in = valid ? t.dat[cur] : WIDTH'($urandom);
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
        end
        valid = 1'b0;
        start = 1'b0;
        chk({tg, "_done_cycle"}, done_cyc, t.exp_done);
        chk({tg, "_ndone"}, ndone, 1);
        chk({tg, "_reqs"}, nreq, t.exp_reqs);
        chk({tg, "_err"}, int'(err), t.exp_err);
        chk({tg, "_busy_cycles"}, busy_n, t.exp_done - 1);
        chk({tg, "_req_idx_bad"}, idx_bad, 0);
        chk({tg, "_idx_hold_bad"}, hold_bad, 0);
        chk({tg, "_idle_idx"}, int'(idx), 0);
        for (int i = 0; i < t.exp_reqs - t.exp_err; i++) begin
            exp_cnt[i] = t.dat[i];
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_cnt%0d", tg, i),
                int'(cnt_a[i]), int'(exp_cnt[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        row_t r;
        int   d, e, q;
        reset_L = 1'b0;
        start   = 1'b0;
        valid   = 1'b0;
        data_in = '0;
        for (int i = 0; i < 5; i++) exp_cnt[i] = '0;

        // lat0..4, dat0..4, extra, rst_at, done, err, reqs
        tbl[0] = mk(1, 1, 1, 1, 1, 3, 7, 0, 31, 12, 0, 0, 11, 0, 5);
        tbl[1] = mk(4, 4, 4, 4, 4, 1, 2, 4, 8, 16, 0, 0, 26, 0, 5);
        tbl[2] = mk(1, 1, 0, 1, 1, 9, 10, 11, 12, 13, 0, 0, 14, 1, 3);
        tbl[3] = mk(1, 1, 1, 1, 1, 5, 6, 7, 8, 9, 1, 0, 11, 0, 5);
        tbl[4] = mk(8, 8, 8, 8, 8, 31, 30, 29, 28, 27, 0, 0, 46, 0, 5);
        tbl[5] = mk(9, 1, 1, 1, 1, 20, 21, 22, 23, 24, 0, 0, 10, 1, 1);
        tbl[6] = mk(1, 1, 1, 1, 1, 1, 2, 3, 4, 5, 0, 8, 0, 0, 4);
        tbl[7] = mk(1, 1, 1, 1, 1, 3, 7, 0, 31, 12, 0, 0, 11, 0, 5);
        tbl[8] = mk(2, 7, 1, 3, 8, 17, 0, 31, 1, 22, 0, 0, 27, 0, 5);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_req", int'(req), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_idx", int'(idx), 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("reset_cnt%0d", i), int'(cnt_a[i]), 0);
        end
        reset_L = 1'b1;

        // stray replies while idle must not be captured
        @(negedge clk);
        valid = 1'b1;
        repeat (4) begin
            data_in = WIDTH'($urandom_range(1, 31));
            @(negedge clk);
        end
        valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_req", int'(req), 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("idle_cnt%0d", i), int'(cnt_a[i]), 0);
        end

        for (int k = 0; k < 9; k++) begin
            run_sweep(tbl[k], $sformatf("row%0d", k));
        end

        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if ($urandom_range(0, 11) == 0)
                    r.lat[i] = 4'($urandom_range(0, 1) == 0 ? 0 : 9);
                else
                    r.lat[i] = 4'($urandom_range(1, TIMEOUT));
                r.dat[i] = WIDTH'($urandom);
            end
            r.extra  = ($urandom_range(0, 1) == 1);
            r.rst_at = 0;
            model(r.lat, d, e, q);
            r.exp_done = d;
            r.exp_err  = e;
            r.exp_reqs = q;
            run_sweep(r, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
